mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer_pkg.sv | 50 +++++
 rtl/mdu_sequencer_mul_pipe.sv | 39 +++
 rtl/mdu_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg
//   Shared CPU defines for the multiply/divide unit: operation and state
//   encodings, default latencies, HILO accumulate-mode codes and small
//   decode helpers used by the sequencer.
package mdu_sequencer_pkg;

  // Operation encoding as presented by the EXE stage on the 3-bit op bus.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  localparam int MDU_MUL_LAT_DEFAULT  = 2;
  localparam int MDU_DIV_ITER_DEFAULT = 32;

  // HILO accumulate modes reported alongside the result.
  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_ADD  = 2'b01;
  localparam logic [1:0] EXT_SUB  = 2'b10;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  function automatic logic [1:0] op_ext_mode(input mdu_op_e op);
    case (op)
      OP_MADD, OP_MADDU: return EXT_ADD;
      OP_MSUB, OP_MSUBU: return EXT_SUB;
      default:           return EXT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mdu_sequencer_mul_pipe.sv
// mdu_mul_pipe
//   Pure datapath: LAT-stage pipelined 33x33 signed multiplier. The caller
//   chooses sign- or zero-extension through bit 32 of each operand. A product
//   presented at cycle t appears on prod_o during cycle t+LAT.
// Ports
//   clk     clock
//   a_i     33-bit signed multiplicand
//   b_i     33-bit signed multiplier
//   prod_o  low 64 bits of the product
module mdu_mul_pipe #(
  parameter int LAT = 2
) (
  input  logic               clk,
  input  logic signed [32:0] a_i,
  input  logic signed [32:0] b_i,
  output logic [63:0]        prod_o
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic [63:0]        stage_q [LAT];

  // The low 64 bits of a 64x64 product of the sign-extended operands equal
  // the low 64 bits of the exact 66-bit product.
  assign a_ext = {{31{a_i[32]}}, a_i};
  assign b_ext = {{31{b_i[32]}}, b_i};

  // Multiply in the first stage; later stages only carry the product so
  // retiming can spread the multiplier across them.
  always_ff @(posedge clk) begin
    stage_q[0] <= a_ext * b_ext;
    for (int i = 1; i < LAT; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign prod_o = stage_q[LAT-1];

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Multi-cycle multiply/divide sequencer for the EXE stage. Multiplies run
//   through a pipelined multiplier for MUL_LAT cycles; divides run DIV_ITER
//   one-bit restoring iterations. The result is presented with a one-cycle
//   finish pulse that doubles as the HILO write enable.
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   flush      EXE flush, aborts any operation in flight
//   start      EXE holds a mult/div op (level, held while stall=1)
//   op         operation (mdu_op_e encoding)
//   src_a      rs operand
//   src_b      rt operand
//   stall      stall request to EXE
//   finish     one-cycle HILO write enable
//   hi_out     product high / remainder
//   lo_out     product low / quotient
//   extend_op  HILO accumulate mode (00 none, 01 add, 10 subtract)
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MUL_LAT  = MDU_MUL_LAT_DEFAULT,
  parameter int DIV_ITER = MDU_DIV_ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        finish,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [1:0]  extend_op
);

  localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  mdu_op_e     op_e;
  mdu_op_e     op_q;
  logic        accept;
  logic        in_signed;
  logic        div_by_zero;

  // Divider state: partial remainder, quotient/dividend shift register,
  // divisor magnitude and the sign corrections to apply at the end.
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        q_neg_q;
  logic        r_neg_q;

  logic [31:0] hi_q, lo_q;
  logic [1:0]  ext_q;

  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] div_a_abs, div_b_abs;
  logic        div_step, div_last, mul_last;

  logic [32:0] mul_a, mul_b;
  logic [63:0] mul_prod;

  assign op_e        = mdu_op_e'(op);
  assign accept      = (state_q == MDU_IDLE) && start && !flush;
  assign in_signed   = op_is_signed(op_e);
  assign div_by_zero = (src_b == 32'd0);

  // ---------------------------------------------------------------------
  // Multiplier: operands go straight from the forwarded buses, which EXE
  // holds stable while stalled, so the product at the last MUL cycle
  // belongs to the accepted instruction.
  // ---------------------------------------------------------------------
  assign mul_a = {in_signed & src_a[31], src_a};
  assign mul_b = {in_signed & src_b[31], src_b};

  mdu_mul_pipe #(
    .LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk    (clk),
    .a_i    (mul_a),
    .b_i    (mul_b),
    .prod_o (mul_prod)
  );

  // ---------------------------------------------------------------------
  // Restoring divide step
  // ---------------------------------------------------------------------
  assign div_a_abs = (in_signed && src_a[31]) ? -src_a : src_a;
  assign div_b_abs = (in_signed && src_b[31]) ? -src_b : src_b;

  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  // When rem_ge holds the true difference is below 2^32, so 32 bits suffice.
  assign rem_sub   = rem_shift[31:0] - dvs_q;
  assign rem_step  = rem_ge ? rem_sub : rem_shift[31:0];
  assign quo_step  = {quo_q[30:0], rem_ge};

  assign div_step = (state_q == MDU_DIV) && !flush;
  assign div_last = div_step && (cnt_q == '0);
  assign mul_last = (state_q == MDU_MUL) && !flush && (cnt_q == '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and cycle counter
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          if (!op_is_div(op_e)) begin
            state_d = MDU_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else if (div_by_zero) begin
            state_d = MDU_DONE;
          end else begin
            state_d = MDU_DIV;
            cnt_d   = CNT_W'(DIV_ITER - 1);
          end
        end
      end
      MDU_MUL, MDU_DIV: begin
        if (cnt_q == '0) begin
          state_d = MDU_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (flush) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    stall  = 1'b0;
    finish = 1'b0;
    if (!rst) begin
      stall  = accept || (state_q == MDU_MUL) || (state_q == MDU_DIV);
      finish = (state_q == MDU_DONE) && !flush;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Results are written only on entry to DONE so they
  // stay stable until the next operation completes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_MULT;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ext_q   <= EXT_NONE;
    end else begin
      if (accept) begin
        op_q    <= op_e;
        rem_q   <= '0;
        quo_q   <= div_a_abs;
        dvs_q   <= div_b_abs;
        q_neg_q <= in_signed && (src_a[31] ^ src_b[31]);
        r_neg_q <= in_signed && src_a[31];
        if (op_is_div(op_e) && div_by_zero) begin
          hi_q  <= src_a;
          lo_q  <= '1;
          ext_q <= EXT_NONE;
        end
      end
      if (div_step) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
      end
      if (div_last) begin
        hi_q  <= r_neg_q ? -rem_step : rem_step;
        lo_q  <= q_neg_q ? -quo_step : quo_step;
        ext_q <= EXT_NONE;
      end
      if (mul_last) begin
        hi_q  <= mul_prod[63:32];
        lo_q  <= mul_prod[31:0];
        ext_q <= op_ext_mode(op_q);
      end
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign extend_op = ext_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] MADD  = 3'd2;
  localparam logic [2:0] MADDU = 3'd3;
  localparam logic [2:0] MSUB  = 3'd4;
  localparam logic [2:0] MSUBU = 3'd5;
  localparam logic [2:0] DIV   = 3'd6;
  localparam logic [2:0] DIVU  = 3'd7;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, finish;
  logic [31:0] hi_out, lo_out;
  logic [1:0]  extend_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(
    .MUL_LAT  (MUL_LAT),
    .DIV_ITER (DIV_ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .stall     (stall),
    .finish    (finish),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .extend_op (extend_op)
  );

  // Reference: plain arithmetic on 64-bit integers.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic [1:0] ext, output int lat);
    longint pa, pb, q, r;
    logic [63:0] p;
    bit sgn;
    sgn = (o == MULT) || (o == MADD) || (o == MSUB) || (o == DIV);
    pa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    pb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    ext = 2'b00;
    if (o <= MSUBU) begin
      p   = 64'(pa * pb);
      hi  = p[63:32];
      lo  = p[31:0];
      if (o == MADD || o == MADDU) ext = 2'b01;
      if (o == MSUB || o == MSUBU) ext = 2'b10;
      lat = MUL_LAT + 1;
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      q   = pa / pb;
      r   = pa % pb;
      lo  = q[31:0];
      hi  = r[31:0];
      lat = DIV_ITER + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and follow it to completion.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_in_done);
    logic [31:0] ehi, elo;
    logic [1:0]  eext, esf;
    int          lat;
    model(o, a, b, ehi, elo, eext, lat);
    op = o; src_a = a; src_b = b; start = 1'b1; flush = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        start = hold_in_done;
        op    = ~o;
      end
      #1;
      esf = (c < lat) ? 2'b10 : 2'b01;
      checks++;
      if ({stall, finish} !== esf) begin
        errors++;
        $display("FAIL %s cycle %0d stall,finish=%b expected %b", name, c, {stall, finish}, esf);
      end
      if (c == lat) begin
        checks++;
        if (hi_out !== ehi) begin
          errors++;
          $display("FAIL %s hi_out=%h expected %h", name, hi_out, ehi);
        end
        checks++;
        if (lo_out !== elo) begin
          errors++;
          $display("FAIL %s lo_out=%h expected %h", name, lo_out, elo);
        end
        checks++;
        if (extend_op !== eext) begin
          errors++;
          $display("FAIL %s extend_op=%b expected %b", name, extend_op, eext);
        end
      end
      tick();
    end
    start = 1'b0;
    #1;
    checks++;
    if ({stall, finish, hi_out, lo_out, extend_op} !== {2'b00, ehi, elo, eext}) begin
      errors++;
      $display("FAIL %s_after stall,finish=%b hi=%h lo=%h ext=%b expected 00 %h %h %b",
               name, {stall, finish}, hi_out, lo_out, extend_op, ehi, elo, eext);
    end
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h ext=%b lat=%0d", name, o, a, b, hi_out, lo_out, extend_op, lat);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start = 1'b1; op = MULT; src_a = 32'd5; src_b = 32'd6;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall cycle %0d stall=%b expected 0", c, stall);
      end
      tick();
    end
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({stall, finish, hi_out, lo_out, extend_op} !== 68'd0) begin
      errors++;
      $display("FAIL reset_state stall,finish=%b hi=%h lo=%h ext=%b expected all zero",
               {stall, finish}, hi_out, lo_out, extend_op);
    end
    $display("reset done");
    tick();
  endtask

  task automatic test_directed();
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("div_wrap", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 1'b0);
    run_op("div_by0_neg", DIV, 32'h8000_0001, 32'd0, 1'b1);
    run_op("madd", MADD, 32'hFFFF_FFFE, 32'd7, 1'b1);
    run_op("msubu", MSUBU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
  endtask

  // Flush during DIV, then a new multiply; also flush during MUL.
  task automatic test_flush();
    op = DIVU; src_a = 32'd1000; src_b = 32'd7; start = 1'b1; flush = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      flush = (c == 10);
      #1;
      checks++;
      if ({stall, finish} !== 2'b10) begin
        errors++;
        $display("FAIL flush_div cycle %0d stall,finish=%b expected 10", c, {stall, finish});
      end
      tick();
    end
    flush = 1'b0; start = 1'b0;
    for (int c = 11; c < 50; c++) begin
      #1;
      checks++;
      if ({stall, finish} !== 2'b00) begin
        errors++;
        $display("FAIL flush_div_idle cycle %0d stall,finish=%b expected 00", c, {stall, finish});
      end
      tick();
    end
    $display("flush during DIVU: no finish");
    run_op("mult_3_m2", MULT, 32'd3, 32'hFFFF_FFFE, 1'b0);

    op = MULTU; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    #1;
    tick();
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0; start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({stall, finish, lo_out} !== {2'b00, 32'hFFFF_FFFA}) begin
        errors++;
        $display("FAIL flush_mul cycle %0d stall,finish=%b lo=%h expected 00 fffffffa",
                 c, {stall, finish}, lo_out);
      end
      tick();
    end
    $display("flush during MUL: no finish, result kept");
  endtask

  // Flush coinciding with DONE suppresses finish; start with flush is ignored.
  task automatic test_flush_done_and_start();
    op = MULT; src_a = 32'd4; src_b = 32'd4; start = 1'b1; flush = 1'b0;
    for (int c = 0; c < MUL_LAT + 1; c++) begin
      #1;
      tick();
    end
    start = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({stall, finish} !== 2'b00) begin
      errors++;
      $display("FAIL flush_done stall,finish=%b expected 00", {stall, finish});
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({stall, finish} !== 2'b00) begin
      errors++;
      $display("FAIL flush_done_next stall,finish=%b expected 00", {stall, finish});
    end
    tick();
    $display("flush in DONE: finish suppressed");

    op = MULTU; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL start_flush stall=%b expected 0", stall);
    end
    tick();
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({stall, finish} !== 2'b00) begin
        errors++;
        $display("FAIL start_flush_after cycle %0d stall,finish=%b expected 00", c, {stall, finish});
      end
      tick();
    end
    $display("start with flush: ignored");
  endtask

  // MSUB result visible, then reset mid-divide clears everything.
  task automatic test_reset_mid_op();
    run_op("msub_3_4", MSUB, 32'd3, 32'd4, 1'b0);
    op = DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall stall=%b expected 0", stall);
    end
    tick();
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({hi_out, lo_out, extend_op} !== 66'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs hi=%h lo=%h ext=%b expected 0", hi_out, lo_out, extend_op);
    end
    for (int c = 0; c < DIV_ITER + 5; c++) begin
      checks++;
      if ({stall, finish} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_idle cycle %0d stall,finish=%b expected 00", c, {stall, finish});
      end
      tick();
    end
    $display("reset mid-DIV: outputs cleared, no finish");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    for (int n = 0; n < 30; n++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'd1;
      if (sel == 3) b = b >> $urandom_range(1, 31);
      run_op("random", o, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  // Operations issued one after another from consecutive idle slots.
  task automatic test_back_to_back();
    run_op("b2b_div", DIV, 32'd77, 32'hFFFF_FFF6, 1'b0);
    run_op("b2b_maddu", MADDU, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
    run_op("b2b_divu0", DIVU, 32'hCAFE_0000, 32'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    tick();
    test_reset();
    test_directed();
    test_flush();
    test_flush_done_and_start();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
